// File: rtl/retire_stage_if.sv
// Retire-side bus between the ROB head and the retire stage, plus the shared ROB entry type.
// The ROB (or bench) drives through master; retire_stage consumes through slave.
package retire_stage_pkg;
    localparam int unsigned PR_W   = 6;
    localparam int unsigned XLEN_W = 32;

    typedef struct packed {
        logic              valid;
        logic              completed;
        logic              halt;
        logic              precise_state_need;
        logic [XLEN_W-1:0] target_pc;
        logic [4:0]        arch_reg;
        logic [PR_W-1:0]   told;
        logic [PR_W-1:0]   tnew;
    } rob_entry_packet_t;
endpackage

interface retire_stage_if #(
    parameter int unsigned CNT_W = 32
);
    retire_stage_pkg::rob_entry_packet_t [2:0]       rob_head_entry;
    logic [2:0]                                      retire_valid;
    logic [2:0]                                      fl_free_valid;
    logic [2:0][retire_stage_pkg::PR_W-1:0]          fl_free_pr;
    logic [2:0]                                      amt_we;
    logic [2:0][4:0]                                 amt_ar;
    logic [2:0][retire_stage_pkg::PR_W-1:0]          amt_pr;
    logic                                            BPRecoverEN;
    logic [retire_stage_pkg::XLEN_W-1:0]             recover_pc;
    logic                                            halt;
    logic [CNT_W-1:0]                                retired_count;

    modport master (
        output rob_head_entry,
        input  retire_valid, fl_free_valid, fl_free_pr, amt_we, amt_ar, amt_pr,
        input  BPRecoverEN, recover_pc, halt, retired_count
    );

    modport slave (
        input  rob_head_entry,
        output retire_valid, fl_free_valid, fl_free_pr, amt_we, amt_ar, amt_pr,
        output BPRecoverEN, recover_pc, halt, retired_count
    );
endinterface

// File: rtl/retire_stage.sv
// In-order commit of up to three ROB head entries (way 2 oldest), with free-list release,
// architectural map update, mispredict recovery pulse and sticky halt.
module retire_stage #(
    parameter int unsigned RETIRE_WIDTH = 3,
    parameter int unsigned PR_W         = retire_stage_pkg::PR_W,
    parameter int unsigned XLEN_W       = retire_stage_pkg::XLEN_W,
    parameter int unsigned CNT_W        = 32
) (
    input logic          clock,
    input logic          reset,
    retire_stage_if.slave bus
);
    typedef enum logic [1:0] {StRun, StRecover, StHalted} state_e;

    state_e                       state_q;
    logic                         bp_recover_q;
    logic [XLEN_W-1:0]            recover_pc_q;
    logic                         halt_q;
    logic [CNT_W-1:0]             count_q;

    logic [RETIRE_WIDTH-1:0]      commit;
    logic [RETIRE_WIDTH-1:0]      free_valid;
    logic [RETIRE_WIDTH-1:0]      map_we;
    logic [RETIRE_WIDTH-1:0][PR_W-1:0] free_pr;
    logic [RETIRE_WIDTH-1:0][4:0] map_ar;
    logic [RETIRE_WIDTH-1:0][PR_W-1:0] map_pr;
    logic                         chain;
    logic                         halt_hit;
    logic                         mp_hit;
    logic [XLEN_W-1:0]            mp_pc;
    logic [CNT_W-1:0]             commit_cnt;
    retire_stage_pkg::rob_entry_packet_t e;

    // Walk oldest to youngest; a blocked or serialising way stops the chain.
    always_comb begin
        commit     = '0;
        free_valid = '0;
        map_we     = '0;
        free_pr    = '0;
        map_ar     = '0;
        map_pr     = '0;
        halt_hit   = 1'b0;
        mp_hit     = 1'b0;
        mp_pc      = '0;
        e          = '0;
        commit_cnt = '0;
        chain      = (state_q == StRun);
        for (int i = RETIRE_WIDTH - 1; i >= 0; i--) begin
            e = bus.rob_head_entry[i];
            if (chain && e.valid && e.completed) begin
                commit[i]  = 1'b1;
                commit_cnt = commit_cnt + CNT_W'(1);
                free_pr[i] = e.told;
                map_ar[i]  = e.arch_reg;
                map_pr[i]  = e.tnew;
                if (!e.halt && e.arch_reg != 5'd0) begin
                    free_valid[i] = 1'b1;
                    map_we[i]     = 1'b1;
                end
                if (e.halt) begin
                    halt_hit = 1'b1;
                end else if (e.precise_state_need) begin
                    mp_hit = 1'b1;
                    mp_pc  = e.target_pc;
                end
                chain = !e.halt && !e.precise_state_need;
            end else begin
                chain = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            bp_recover_q <= 1'b0;
            recover_pc_q <= '0;
            halt_q       <= 1'b0;
            count_q      <= '0;
        end else begin
            count_q <= count_q + commit_cnt;
            case (state_q)
                StRun: begin
                    if (halt_hit) begin
                        state_q <= StHalted;
                        halt_q  <= 1'b1;
                    end else if (mp_hit) begin
                        state_q      <= StRecover;
                        bp_recover_q <= 1'b1;
                        recover_pc_q <= mp_pc;
                    end
                end
                StRecover: begin
                    state_q      <= StRun;
                    bp_recover_q <= 1'b0;
                end
                StHalted: state_q <= StHalted;
                default:  state_q <= StRun;
            endcase
        end
    end

    assign bus.retire_valid  = commit;
    assign bus.fl_free_valid = free_valid;
    assign bus.fl_free_pr    = free_pr;
    assign bus.amt_we        = map_we;
    assign bus.amt_ar        = map_ar;
    assign bus.amt_pr        = map_pr;
    assign bus.BPRecoverEN   = bp_recover_q;
    assign bus.recover_pc    = recover_pc_q;
    assign bus.halt          = halt_q;
    assign bus.retired_count = count_q;
endmodule

// File: tb/tb_retire_stage.sv
// Directed bench for retire_stage: commit patterns, blocking, arch_reg 0, mispredict,
// halt and asynchronous reset, all against hand-computed expectations.
module tb_retire_stage;
    import retire_stage_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_total = 0;
    int   n_bad   = 0;

    retire_stage_if #(.CNT_W(32)) bus ();

    retire_stage #(.CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic rob_entry_packet_t mk(input logic v, input logic c, input logic h,
                                             input logic p, input logic [31:0] pc,
                                             input logic [4:0] ar, input logic [5:0] told,
                                             input logic [5:0] tnew);
        rob_entry_packet_t r;
        r.valid              = v;
        r.completed          = c;
        r.halt               = h;
        r.precise_state_need = p;
        r.target_pc          = pc;
        r.arch_reg           = ar;
        r.told               = told;
        r.tnew               = tnew;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_heads(input rob_entry_packet_t w2, input rob_entry_packet_t w1,
                             input rob_entry_packet_t w0);
        bus.rob_head_entry[2] = w2;
        bus.rob_head_entry[1] = w1;
        bus.rob_head_entry[0] = w0;
    endtask

    rob_entry_packet_t z;

    initial begin
        z = '0;
        set_heads(z, z, z);
        #3;
        check_eq("rst_bp",    64'(bus.BPRecoverEN), 64'd0);
        check_eq("rst_halt",  64'(bus.halt), 64'd0);
        check_eq("rst_count", 64'(bus.retired_count), 64'd0);
        #9 reset = 1'b1;   // t=12, between edges
        #1;
        check_eq("idle_rv",   64'(bus.retire_valid), 64'd0);
        check_eq("idle_pc",   64'(bus.recover_pc), 64'd0);

        // All three commit
        set_heads(mk(1, 1, 0, 0, 0, 5'd1, 6'd1, 6'd32),
                  mk(1, 1, 0, 0, 0, 5'd2, 6'd2, 6'd33),
                  mk(1, 1, 0, 0, 0, 5'd3, 6'd3, 6'd34));
        #1;
        check_eq("all_rv",    64'(bus.retire_valid), 64'b111);
        check_eq("all_flv",   64'(bus.fl_free_valid), 64'b111);
        check_eq("all_flpr",  64'(bus.fl_free_pr), 64'({6'd1, 6'd2, 6'd3}));
        check_eq("all_we",    64'(bus.amt_we), 64'b111);
        check_eq("all_ar",    64'(bus.amt_ar), 64'({5'd1, 5'd2, 5'd3}));
        check_eq("all_pr",    64'(bus.amt_pr), 64'({6'd32, 6'd33, 6'd34}));
        tick();
        check_eq("all_cnt",   64'(bus.retired_count), 64'd3);

        // Way 1 incomplete blocks way 0
        set_heads(mk(1, 1, 0, 0, 0, 5'd1, 6'd1, 6'd32),
                  mk(1, 0, 0, 0, 0, 5'd2, 6'd2, 6'd33),
                  mk(1, 1, 0, 0, 0, 5'd3, 6'd3, 6'd34));
        #1;
        check_eq("blk_rv",    64'(bus.retire_valid), 64'b100);
        check_eq("blk_flv",   64'(bus.fl_free_valid), 64'b100);
        check_eq("blk_flpr",  64'(bus.fl_free_pr), 64'({6'd1, 6'd0, 6'd0}));
        tick();
        check_eq("blk_cnt",   64'(bus.retired_count), 64'd4);

        // arch_reg 0 retires without side effects; invalid younger ways
        set_heads(mk(1, 1, 0, 0, 0, 5'd0, 6'd7, 6'd40), z, z);
        #1;
        check_eq("r0_rv",     64'(bus.retire_valid), 64'b100);
        check_eq("r0_flv",    64'(bus.fl_free_valid), 64'b000);
        check_eq("r0_we",     64'(bus.amt_we), 64'b000);
        tick();
        check_eq("r0_cnt",    64'(bus.retired_count), 64'd5);

        // Mispredict on way 1
        set_heads(mk(1, 1, 0, 0, 0, 5'd4, 6'd4, 6'd35),
                  mk(1, 1, 0, 1, 32'd32, 5'd5, 6'd5, 6'd36),
                  mk(1, 1, 0, 0, 0, 5'd6, 6'd6, 6'd37));
        #1;
        check_eq("mp_rv",     64'(bus.retire_valid), 64'b110);
        check_eq("mp_we",     64'(bus.amt_we), 64'b110);
        check_eq("mp_bp0",    64'(bus.BPRecoverEN), 64'd0);
        tick();
        check_eq("mp_bp1",    64'(bus.BPRecoverEN), 64'd1);
        check_eq("mp_pc",     64'(bus.recover_pc), 64'd32);
        check_eq("mp_rv_rec", 64'(bus.retire_valid), 64'b000);
        check_eq("mp_flv_rec", 64'(bus.fl_free_valid), 64'b000);
        check_eq("mp_cnt",    64'(bus.retired_count), 64'd7);
        tick();
        check_eq("mp_bp_end", 64'(bus.BPRecoverEN), 64'd0);
        check_eq("mp_cnt2",   64'(bus.retired_count), 64'd7);
        check_eq("mp_resume", 64'(bus.retire_valid), 64'b110);
        set_heads(z, z, z);
        #1;
        check_eq("empty_rv",  64'(bus.retire_valid), 64'b000);
        tick();
        check_eq("empty_cnt", 64'(bus.retired_count), 64'd7);

        // Halt with precise_state_need on the same entry: halt wins
        set_heads(mk(1, 1, 1, 1, 32'd99, 5'd8, 6'd8, 6'd41),
                  mk(1, 1, 0, 0, 0, 5'd9, 6'd9, 6'd42),
                  mk(1, 1, 0, 0, 0, 5'd10, 6'd10, 6'd43));
        #1;
        check_eq("h_rv",      64'(bus.retire_valid), 64'b100);
        check_eq("h_we",      64'(bus.amt_we), 64'b000);
        check_eq("h_flv",     64'(bus.fl_free_valid), 64'b000);
        tick();
        check_eq("h_halt",    64'(bus.halt), 64'd1);
        check_eq("h_bp",      64'(bus.BPRecoverEN), 64'd0);
        check_eq("h_rv2",     64'(bus.retire_valid), 64'b000);
        check_eq("h_cnt",     64'(bus.retired_count), 64'd8);
        tick();
        tick();
        check_eq("h_sticky",  64'(bus.halt), 64'd1);
        check_eq("h_cnt2",    64'(bus.retired_count), 64'd8);

        // Asynchronous reset from HALTED
        #2 reset = 1'b0;
        #1;
        check_eq("ar_h_halt", 64'(bus.halt), 64'd0);
        check_eq("ar_h_cnt",  64'(bus.retired_count), 64'd0);
        set_heads(z, z, z);
        tick();
        reset = 1'b1;

        // Asynchronous reset mid-RECOVER
        set_heads(mk(1, 1, 0, 1, 32'h40, 5'd2, 6'd2, 6'd50), z, z);
        tick();
        check_eq("ar_r_bp1",  64'(bus.BPRecoverEN), 64'd1);
        check_eq("ar_r_pc1",  64'(bus.recover_pc), 64'h40);
        check_eq("ar_r_cnt1", 64'(bus.retired_count), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_r_bp0",  64'(bus.BPRecoverEN), 64'd0);
        check_eq("ar_r_pc0",  64'(bus.recover_pc), 64'd0);
        check_eq("ar_r_cnt0", 64'(bus.retired_count), 64'd0);
        check_eq("ar_r_halt", 64'(bus.halt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/retire_stage.md
Name: retire_stage

Overview:
- Consumer end of the ROB retire interface. Each cycle it inspects the three ROB head entries and decides in program order which of them commit.
- For each committed entry it frees Told to the free list and writes Tnew into the architectural map table.
- A committed mispredicted branch raises a one-cycle BPRecoverEN pulse with the redirect PC.
- A committed halt stops the machine.

Parameters:
- RETIRE_WIDTH, 3, number of retire ways; fixed at 3 (way 2 oldest, way 0 youngest).
- PR_W, `PR, physical register tag width.
- XLEN_W, `XLEN, PC width.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- rob_head_entry  input  [2:0] ROB_ENTRY_PACKET  head entries from the ROB; way 2 = ROB head (oldest).
- retire_valid  output  3  per-way commit this cycle; always a prefix from way 2 (100, 110, 111, or 000); the ROB advances head by popcount at the next rising edge.
- fl_free_valid  output  3  per-way free-list release strobe.
- fl_free_pr  output  [2:0][PR_W-1:0]  Told of each freed way.
- amt_we  output  3  per-way architectural map write enable.
- amt_ar  output  [2:0][4:0]  arch_reg of each written way.
- amt_pr  output  [2:0][PR_W-1:0]  Tnew of each written way.
- BPRecoverEN  output  1  registered one-cycle pulse requesting pipeline flush and recovery.
- recover_pc  output  XLEN_W  redirect target; valid while BPRecoverEN = 1.
- halt  output  1  sticky; set once a halt entry commits.
- retired_count  output  CNT_W  running count of committed instructions.

Behaviour:
- State machine {RUN, RECOVER, HALTED}. Reset (reset = 0, asynchronous) forces:
  - state = RUN;
  - BPRecoverEN = 0, recover_pc = 0, halt = 0, retired_count = 0.
- Commit eligibility, combinational from rob_head_entry and state:
  - ok[i] = valid & completed.
  - Commit is allowed only in state RUN; in RECOVER and HALTED, retire_valid = 000 and all strobes = 0.
  - Way 2 commits if ok[2].
  - Way 1 commits if way 2 commits, way 2 has neither halt nor precise_state_need, and ok[1].
  - Way 0 commits under the same rule applied to way 1.
  - An incomplete or invalid older way blocks all younger ways; nothing commits out of order.
- Per committed way i:
  - fl_free_valid[i] = 1, fl_free_pr[i] = Told.
  - amt_we[i] = 1, amt_ar[i] = arch_reg, amt_pr[i] = Tnew.
  - If arch_reg == 0, fl_free_valid[i] and amt_we[i] are both 0, but the way still retires.
  - Entries with halt = 1 never write the map table or free a register.
  - All strobes are 0 for non-committed ways; their data outputs are don't-care and driven 0.
- Mispredict (a committed way has precise_state_need = 1 and halt = 0):
  - The next state is RECOVER. recover_pc is registered from that entry's target_pc.
  - BPRecoverEN = 1 for exactly the cycle spent in RECOVER.
  - RECOVER lasts one cycle, then returns to RUN. The ROB and the front end flush on that pulse.
- Halt (a committed way has halt = 1): the next state is HALTED, and halt = 1 from the next cycle until reset.
  - If halt and precise_state_need are set on the same entry, halt wins and no recovery pulse occurs.
- retired_count:
  - Increments by popcount(retire_valid) at each rising edge, including halt entries.
  - Wraps modulo 2^CNT_W.
- Stable inputs with no eligible entry hold all state; outputs stay 0 except the registered ones.
- Reset asserted mid-RECOVER or in HALTED clears everything immediately, without waiting for a clock edge.

Test Plan:
- Reset low, then high with rob_head_entry = 0 -> all outputs 0, retired_count = 0, state RUN.
- Ways 2/1/0 valid+completed, Told 1/2/3, Tnew 32/33/34, arch 1/2/3 -> retire_valid = 111, fl_free_pr = {1,2,3}, amt writes (1→32, 2→33, 3→34); retired_count = 3 next cycle.
- Way 2 completed, way 1 not completed, way 0 completed -> retire_valid = 100; only Told 1 is freed.
- Way 1 has precise_state_need = 1, target_pc = 32, all completed -> retire_valid = 110.
  - Next cycle: BPRecoverEN = 1, recover_pc = 32, retire_valid = 000.
  - Cycle after: BPRecoverEN = 0, commits resume.
- Way 2 halt = 1, ways 1/0 completed -> retire_valid = 100 with no amt_we or fl_free_valid.
  - halt = 1 from the next cycle and stays 1; retire_valid stays 000; retired_count stays +1.
- Drive reset = 0 between clock edges while BPRecoverEN = 1 -> BPRecoverEN, halt and retired_count drop to 0 immediately.
